// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD access scheduler: FSM encoding and the power-on init command ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWER_WAIT,
        ST_INIT_ISSUE,
        ST_INIT_WAIT_BUSY,
        ST_INIT_WAIT_DONE,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    localparam int unsigned INIT_LEN = 6;
    localparam int unsigned INIT_IW  = 3;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h80;

    // HD44780 4-bit wake-up, function set, display on, clear, entry mode
    function automatic logic [7:0] init_byte(input logic [INIT_IW-1:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h33;
            3'd1:    init_byte = 8'h32;
            3'd2:    init_byte = 8'h28;
            3'd3:    init_byte = 8'h0C;
            3'd4:    init_byte = LCD_CMD_CLEAR;
            3'd5:    init_byte = 8'h06;
            default: init_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an optional lock that forces the grant to a fixed requester.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    input  logic                       lock_valid,
    input  logic [$clog2(NUM_REQ)-1:0] lock_owner,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       grant_valid
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0] cand;

    // Locked owner wins outright; otherwise first requester at or above the pointer, wrapping.
    always_comb begin
        grant       = pointer;
        grant_valid = 1'b0;
        cand        = '0;
        if (lock_valid && req[lock_owner]) begin
            grant       = lock_owner;
            grant_valid = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = IW'((32'(pointer) + k) % NUM_REQ);
                if (!grant_valid && req[cand]) begin
                    grant       = cand;
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_access_scheduler.sv
// Owns the i2c_lcd byte port: runs the power-on init sequence, then shares the port
// round-robin between requesters, one byte per grant, with an optional burst lock.
module lcd_access_scheduler #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned POWER_WAIT   = 4_000_000,
    parameter int unsigned BUSY_TIMEOUT = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rs,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_lock,
    output logic [NUM_REQ-1:0]     done,
    output logic                   ready,
    output logic                   error,
    output logic                   lcd_send,
    output logic                   lcd_rs,
    output logic [7:0]             lcd_data,
    input  logic                   lcd_busy
);

    import lcd_pkg::*;

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = 32;
    localparam logic [CW-1:0] PW_LAST = CW'(POWER_WAIT - 1);
    localparam logic [CW-1:0] BT_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [INIT_IW-1:0] INIT_LAST = INIT_IW'(INIT_LEN - 1);

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [INIT_IW-1:0]   init_idx, init_idx_d;
    logic [IW-1:0]        owner, owner_d;
    logic [IW-1:0]        pointer, pointer_d;
    logic                 lock_valid, lock_valid_d;
    logic [NUM_REQ-1:0]   done_d;
    logic                 ready_d, error_d, send_d, rs_d;
    logic [7:0]           data_d;
    logic                 init_step;

    logic [IW-1:0]        grant;
    logic                 grant_valid;
    logic                 lock_hold;
    logic [IW-1:0]        next_ptr;

    // Lock only counts while the owner keeps both req and req_lock asserted
    assign lock_hold = lock_valid && req[owner] && req_lock[owner];
    assign next_ptr  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req),
        .pointer     (pointer),
        .lock_valid  (lock_hold),
        .lock_owner  (owner),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        init_idx_d   = init_idx;
        owner_d      = owner;
        pointer_d    = pointer;
        lock_valid_d = lock_valid;
        done_d       = '0;
        ready_d      = ready;
        error_d      = error;
        send_d       = lcd_send;
        rs_d         = lcd_rs;
        data_d       = lcd_data;
        init_step    = 1'b0;

        case (state)
            ST_POWER_WAIT: begin
                if (cnt == PW_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_INIT_ISSUE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_INIT_ISSUE: begin
                data_d  = init_byte(init_idx);
                rs_d    = 1'b0;
                send_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_INIT_WAIT_BUSY;
            end
            ST_INIT_WAIT_BUSY: begin
                if (lcd_busy) begin
                    send_d  = 1'b0;
                    state_d = ST_INIT_WAIT_DONE;
                end else if (cnt == BT_LAST) begin
                    send_d    = 1'b0;
                    error_d   = 1'b1;
                    init_step = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_INIT_WAIT_DONE: begin
                if (!lcd_busy) begin
                    init_step = 1'b1;
                end
            end
            ST_IDLE: begin
                // The done cycle is skipped so the finished requester can retire its request first
                if (done == '0) begin
                    lock_valid_d = lock_hold;
                    if (grant_valid) begin
                        owner_d = grant;
                        data_d  = req_data[{grant, 3'b000} +: 8];
                        rs_d    = req_rs[grant];
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                send_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (lcd_busy) begin
                    send_d  = 1'b0;
                    state_d = ST_WAIT_DONE;
                end else if (cnt == BT_LAST) begin
                    send_d       = 1'b0;
                    error_d      = 1'b1;
                    lock_valid_d = 1'b0;
                    pointer_d    = next_ptr;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!lcd_busy) begin
                    done_d[owner] = 1'b1;
                    state_d       = ST_IDLE;
                    if (req_lock[owner]) begin
                        lock_valid_d = 1'b1;
                    end else begin
                        lock_valid_d = 1'b0;
                        pointer_d    = next_ptr;
                    end
                end
            end
            default: state_d = ST_POWER_WAIT;
        endcase

        // Advance the init ROM whether the byte completed or timed out
        if (init_step) begin
            if (init_idx == INIT_LAST) begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end else begin
                init_idx_d = init_idx + INIT_IW'(1);
                state_d    = ST_INIT_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_POWER_WAIT;
            cnt        <= '0;
            init_idx   <= '0;
            owner      <= '0;
            pointer    <= '0;
            lock_valid <= 1'b0;
            done       <= '0;
            ready      <= 1'b0;
            error      <= 1'b0;
            lcd_send   <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            init_idx   <= init_idx_d;
            owner      <= owner_d;
            pointer    <= pointer_d;
            lock_valid <= lock_valid_d;
            done       <= done_d;
            ready      <= ready_d;
            error      <= error_d;
            lcd_send   <= send_d;
            lcd_rs     <= rs_d;
            lcd_data   <= data_d;
        end
    end

endmodule
